gpca_operand_sequencer: RTL and testbench

- Sequencer directly upstream and downstream of the two-row guarded-carry array (gpca) in the TinyTapeout top.
- Collects the 30 operand/control bits over four byte-wide input beats, holds them stable on the array's inputs, and waits a programmable settle time.
- Captures the array's F/S outputs and returns them over two byte-wide output beats.
- Exists because the 8-bit pin budget cannot present A, B, C, P and X in parallel.

---
 rtl/gpca_pkg.sv | 20 ++
 rtl/gpca_result_unpacker.sv | 47 ++++
 rtl/gpca_operand_sequencer.sv | 127 ++++++++++++
 tb/tb_gpca_operand_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpca_pkg.sv
// Shared widths, beat counts and sequencer state encoding for the gpca operand path.
package gpca_pkg;

    localparam int A_W  = 10;
    localparam int BC_W = 7;
    localparam int P_W  = 5;
    localparam int F_W  = 5;
    localparam int S_W  = 11;

    localparam int IN_BEATS  = 4;
    localparam int OUT_BEATS = 2;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        CAPTURE,
        UNLOAD
    } seq_state_t;

endpackage

// File: rtl/gpca_result_unpacker.sv
// Holds the captured {F,S} result and streams it out as two byte beats with valid/ready.
module gpca_result_unpacker
    import gpca_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           capture,
    input  logic [F_W-1:0] f,
    input  logic [S_W-1:0] s,
    input  logic           out_ready,
    output logic [7:0]     out_data,
    output logic           out_valid,
    output logic           done
);

    logic [F_W+S_W-1:0] result;
    logic               out_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
            out_beat  <= 1'b0;
        end else if (clr) begin
            result    <= '0;
            out_valid <= 1'b0;
            out_beat  <= 1'b0;
        end else if (capture) begin
            result    <= {f, s};
            out_valid <= 1'b1;
            out_beat  <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (out_beat == 1'(OUT_BEATS - 1)) begin
                out_valid <= 1'b0;
                out_beat  <= 1'b0;
            end else begin
                out_beat <= out_beat + 1'b1;
            end
        end
    end

    assign done     = out_valid && out_ready && (out_beat == 1'(OUT_BEATS - 1));
    // Beat 1 carries the flags above the sum's top three bits.
    assign out_data = !out_valid ? 8'h00 : (out_beat ? result[15:8] : result[7:0]);

endmodule

// File: rtl/gpca_operand_sequencer.sv
// Serialises operands into the gpca array over four input beats, waits for it to settle,
// captures its outputs and returns them over two output beats.
module gpca_operand_sequencer
    import gpca_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            soft_clr,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            arr_x,
    output logic [A_W-1:0]  arr_a,
    output logic [BC_W-1:0] arr_b,
    output logic [BC_W-1:0] arr_c,
    output logic [P_W-1:0]  arr_p,
    input  logic [F_W-1:0]  arr_f,
    input  logic [S_W-1:0]  arr_s
);

    seq_state_t      state;
    logic [1:0]      beat_cnt;
    logic [3:0]      settle_cnt;
    logic [A_W-1:0]  reg_a;
    logic [BC_W-1:0] reg_b;
    logic [BC_W-1:0] reg_c;
    logic [P_W-1:0]  reg_p;
    logic            reg_x;
    logic            unload_done;
    logic            capture;
    logic            unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            beat_cnt   <= '0;
            settle_cnt <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            reg_c      <= '0;
            reg_p      <= '0;
            reg_x      <= 1'b0;
            in_ready   <= 1'b0;
        end else if (soft_clr) begin
            state      <= LOAD;
            beat_cnt   <= '0;
            settle_cnt <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            reg_c      <= '0;
            reg_p      <= '0;
            reg_x      <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        case (beat_cnt)
                            2'd0: reg_a[7:0] <= in_data;
                            2'd1: begin
                                reg_a[9:8] <= in_data[1:0];
                                reg_b[5:0] <= in_data[7:2];
                            end
                            2'd2: begin
                                reg_b[6] <= in_data[0];
                                reg_c    <= in_data[7:1];
                            end
                            default: begin
                                reg_p <= in_data[4:0];
                                reg_x <= in_data[5];
                            end
                        endcase
                        if (beat_cnt == 2'(IN_BEATS - 1)) begin
                            state      <= SETTLE;
                            beat_cnt   <= '0;
                            settle_cnt <= 4'(SETTLE_CYCLES - 1);
                            in_ready   <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) state <= CAPTURE;
                    else settle_cnt <= settle_cnt - 4'd1;
                end
                CAPTURE: state <= UNLOAD;
                default: begin
                    if (unload_done) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign capture     = (state == CAPTURE) && !soft_clr;
    assign busy        = !((state == LOAD) && (beat_cnt == 2'd0));
    assign arr_a       = reg_a;
    assign arr_b       = reg_b;
    assign arr_c       = reg_c;
    assign arr_p       = reg_p;
    assign arr_x       = reg_x;
    assign unused_bits = ^in_data[7:6];

    gpca_result_unpacker u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (soft_clr),
        .capture   (capture),
        .f         (arr_f),
        .s         (arr_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .done      (unload_done)
    );

endmodule

// File: tb/tb_gpca_operand_sequencer.sv
// Self-checking bench for gpca_operand_sequencer: fixed vectors, random operations
// against a packed-word reference model, and multi-cycle corner sequences.
module tb_gpca_operand_sequencer;

    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_clr = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        arr_x;
    logic [9:0]  arr_a;
    logic [6:0]  arr_b;
    logic [6:0]  arr_c;
    logic [4:0]  arr_p;
    logic [4:0]  arr_f = 5'h00;
    logic [10:0] arr_s = 11'h000;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [10:0] s;
        logic [4:0]  f;
        logic [9:0]  ea;
        logic [6:0]  eb, ec;
        logic [4:0]  ep;
        logic        ex;
        logic [7:0]  eo0, eo1;
    } vec_t;

    vec_t vecs[5];

    gpca_operand_sequencer #(.SETTLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_clr  (soft_clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .arr_x     (arr_x),
        .arr_a     (arr_a),
        .arr_b     (arr_b),
        .arr_c     (arr_c),
        .arr_p     (arr_p),
        .arr_f     (arr_f),
        .arr_s     (arr_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference view: the four beats form one little-endian 32-bit word, fields packed LSB first.
    task automatic modelFields(input logic [7:0] b0, b1, b2, b3, input logic [10:0] s, input logic [4:0] f,
                               output vec_t v);
        logic [31:0] w;
        logic [15:0] r;
        w = {b3, b2, b1, b0};
        r = {f, s};
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3; v.s = s; v.f = f;
        v.ea = w[9:0];
        v.eb = w[16:10];
        v.ec = w[23:17];
        v.ep = w[28:24];
        v.ex = w[29];
        v.eo0 = r[7:0];
        v.eo1 = r[15:8];
    endtask

    task automatic sendBeat(input logic [7:0] d);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic recvBeat(input int delay, output logic [7:0] d);
        int guard;
        guard = 0;
        repeat (delay) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
        d = out_data;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int delay, output logic [7:0] o0, output logic [7:0] o1);
        arr_s = v.s;
        arr_f = v.f;
        sendBeat(v.b0);
        sendBeat(v.b1);
        sendBeat(v.b2);
        sendBeat(v.b3);
        recvBeat(delay, o0);
        recvBeat(delay, o1);
    endtask

    task automatic checkVector(input string tag, input vec_t v, input logic [7:0] o0, input logic [7:0] o1);
        checkOutput({tag, "_arr_a"}, 32'(arr_a), 32'(v.ea));
        checkOutput({tag, "_arr_b"}, 32'(arr_b), 32'(v.eb));
        checkOutput({tag, "_arr_c"}, 32'(arr_c), 32'(v.ec));
        checkOutput({tag, "_arr_p"}, 32'(arr_p), 32'(v.ep));
        checkOutput({tag, "_arr_x"}, 32'(arr_x), 32'(v.ex));
        checkOutput({tag, "_out0"}, 32'(o0), 32'(v.eo0));
        checkOutput({tag, "_out1"}, 32'(o1), 32'(v.eo1));
    endtask

    initial begin
        logic [7:0] o0, o1;
        vec_t v;
        int n, start;

        vecs[0] = '{8'hA5, 8'h3C, 8'h81, 8'h2D, 11'h5A3, 5'h13, 10'h0A5, 7'h4F, 7'h40, 5'h0D, 1'b1, 8'hA3, 8'h9D};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 11'h7FF, 5'h1F, 10'h3FF, 7'h7F, 7'h7F, 5'h1F, 1'b1, 8'hFF, 8'hFF};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'hC0, 11'h000, 5'h00, 10'h000, 7'h00, 7'h00, 5'h00, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'h01, 8'h02, 8'h04, 8'h08, 11'h400, 5'h01, 10'h201, 7'h00, 7'h02, 5'h08, 1'b0, 8'h00, 8'h0C};
        vecs[4] = '{8'h00, 8'hFC, 8'h01, 8'h20, 11'h0FF, 5'h10, 10'h000, 7'h7F, 7'h00, 5'h00, 1'b1, 8'hFF, 8'h80};

        // Reset state
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_arr", 32'({arr_a, arr_b, arr_c, arr_p, arr_x}), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i % 3, o0, o1);
            checkVector($sformatf("vec%0d", i), vecs[i], o0, o1);
        end

        // Latency and backpressure on the first output beat
        arr_s = 11'h5A3;
        arr_f = 5'h13;
        sendBeat(8'hA5); sendBeat(8'h3C); sendBeat(8'h81); sendBeat(8'h2D);
        checkOutput("in_ready_falls", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checkOutput("latency", 32'(n), 32'(SC + 1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_out_data", 32'(out_data), 32'hA3);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        recvBeat(0, o0);
        recvBeat(0, o1);
        checkOutput("hold_out0", 32'(o0), 32'hA3);
        checkOutput("hold_out1", 32'(o1), 32'h9D);

        // soft_clr after beat 2 with a beat presented in the same cycle
        sendBeat(8'hA5); sendBeat(8'h3C); sendBeat(8'h81);
        in_valid = 1'b1; in_data = 8'h2D; soft_clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; soft_clr = 1'b0;
        checkOutput("clr_arr", 32'({arr_a, arr_b, arr_c, arr_p, arr_x}), 32'd0);
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
        checkOutput("clr_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(vecs[3], 0, o0, o1);
        checkVector("after_clr", vecs[3], o0, o1);

        // Asynchronous reset between clock edges during SETTLE
        arr_s = 11'h123; arr_f = 5'h05;
        sendBeat(8'h11); sendBeat(8'h22); sendBeat(8'h33); sendBeat(8'h04);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_arr", 32'({arr_a, arr_b, arr_c, arr_p, arr_x}), 32'd0);
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_in_ready", 32'(in_ready), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("async_release_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back operations with out_ready tied high
        for (int k = 0; k < 4; k++) begin
            modelFields(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                        11'($urandom), 5'($urandom), v);
            start = cyc;
            out_ready = 1'b1;
            arr_s = v.s; arr_f = v.f;
            sendBeat(v.b0); sendBeat(v.b1); sendBeat(v.b2); sendBeat(v.b3);
            recvBeat(0, o0);
            out_ready = 1'b1;
            recvBeat(0, o1);
            checkOutput("b2b_cycles", 32'(cyc - start), 32'(4 + SC + 1 + 2));
            checkVector($sformatf("b2b%0d", k), v, o0, o1);
        end

        // Randomised operations with random consumer delay
        for (int k = 0; k < 20; k++) begin
            modelFields(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                        11'($urandom), 5'($urandom), v);
            applyStimulus(v, $urandom_range(0, 3), o0, o1);
            checkVector($sformatf("rnd%0d", k), v, o0, o1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
